// File: rtl/cmd_transmitter_if.sv
// Host-side handshake for the one-wire command transmitter.
// The open-drain line itself stays a plain inout on the block.
interface cmd_transmitter_if #(
  parameter int NBITS = 8
);
  logic [NBITS-1:0] frame_in;
  logic             en_cmd_transmit;
  logic             busy;
  logic             done_transmitting;
  logic             collision;

  modport master (
    output frame_in,
    output en_cmd_transmit,
    input  busy,
    input  done_transmitting,
    input  collision
  );

  modport slave (
    input  frame_in,
    input  en_cmd_transmit,
    output busy,
    output done_transmitting,
    output collision
  );
endinterface

// File: rtl/cmd_transmitter.sv
// One-wire command transmitter: LSB-first slots, short low = '1',
// long low = '0', with contention sensing on released '1' bits.
module cmd_transmitter #(
  parameter int SLOT_CYCLES   = 71,
  parameter int LOW1_CYCLES   = 6,
  parameter int LOW0_CYCLES   = 60,
  parameter int SAMPLE_OFFSET = 30,
  parameter int NBITS         = 8
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire               bus,
  cmd_transmitter_if.slave  tx
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [SW-1:0] LOW1_END  = SW'(LOW1_CYCLES - 1);
  localparam logic [SW-1:0] LOW0_END  = SW'(LOW0_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLE_AT = SW'(SAMPLE_OFFSET);
  localparam logic [SW-1:0] SLOT_END  = SW'(SLOT_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);

  if (!(LOW1_CYCLES < SAMPLE_OFFSET &&
        SAMPLE_OFFSET < LOW0_CYCLES &&
        LOW0_CYCLES < SLOT_CYCLES)) begin : g_bad_timing
    $error("cmd_transmitter: illegal slot timing");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    RELEASE,
    DONE
  } state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [SW-1:0]    slot_cnt;
  logic [BW-1:0]    bit_idx;
  logic             drive_low;
  logic             busy;
  logic             done_p;
  logic             collision;
  logic [SW-1:0]    low_end;
  logic             line_low;

  assign low_end  = shreg[0] ? LOW1_END : LOW0_END;
  assign line_low = (bus == 1'b0);

  // Open-drain: only ever pull low, never drive a 1.
  assign bus = drive_low ? 1'b0 : 1'bz;

  assign tx.busy              = busy;
  assign tx.done_transmitting = done_p;
  assign tx.collision         = collision;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      slot_cnt  <= '0;
      bit_idx   <= '0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      done_p    <= 1'b0;
      collision <= 1'b0;
    end else begin
      done_p <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx.en_cmd_transmit) begin
            shreg     <= tx.frame_in;
            slot_cnt  <= '0;
            bit_idx   <= '0;
            collision <= 1'b0;
            drive_low <= 1'b1;
            busy      <= 1'b1;
            state     <= LOW;
          end
        end
        LOW: begin
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_cnt == low_end) begin
            drive_low <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          // A '1' slot should read high here; low means another driver.
          if (slot_cnt == SAMPLE_AT && shreg[0] && line_low) begin
            collision <= 1'b1;
          end
          if (slot_cnt == SLOT_END) begin
            slot_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              busy   <= 1'b0;
              done_p <= 1'b1;
              state  <= DONE;
            end else begin
              shreg     <= shreg >> 1;
              bit_idx   <= bit_idx + 1'b1;
              drive_low <= 1'b1;
              state     <= LOW;
            end
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
